// File: rtl/configure_pkg.sv
// rtl/configure_pkg.sv - shared depth, Avalon response codes and FSM state type for avl_slave
package configure;
   localparam int avl_depth = 4096;

   localparam logic [1:0] AVL_OKAY        = 2'b00;
   localparam logic [1:0] AVL_DECODEERROR = 2'b11;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RBURST = 2'd1,
      WBURST = 2'd2,
      WRESP  = 2'd3
   } avl_slave_state_t;
endpackage

// File: rtl/avl_slave_ram.sv
// rtl/avl_slave_ram.sv - single-port byte-enabled word RAM with registered read
// The read register can be loaded with zero so out-of-range beats return 0 without extra output logic.
module avl_slave_ram
   import configure::*;
#(
   parameter int DEPTH = avl_depth,
   parameter int AW    = $clog2(DEPTH)
) (
   input  logic          i_clk,
   input  logic          i_rst,
   input  logic          i_we,
   input  logic [3:0]    i_be,
   input  logic [AW-1:0] i_addr,
   input  logic [31:0]   i_wdata,
   input  logic          i_re,
   input  logic          i_rd_zero,
   output logic [31:0]   o_rdata
);
   logic [31:0] r_mem [DEPTH];
   logic [31:0] r_rdata;

   always_ff @(posedge i_clk) begin
      if (i_we) begin
         for (int i = 0; i < 4; i++) begin
            if (i_be[i]) begin
               r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
            end
         end
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_rdata <= '0;
      end else if (i_re) begin
         r_rdata <= i_rd_zero ? 32'h0 : r_mem[i_addr];
      end
   end

   assign o_rdata = r_rdata;
endmodule

// File: rtl/avl_slave.sv
// rtl/avl_slave.sv - Avalon-MM burst responder backed by avl_slave_ram
// Optional AVL_SLAVE_RESP_EN: write responses, WRESP state and DECODEERROR reporting.
module avl_slave
   import configure::*;
#(
   parameter int DEPTH = avl_depth
) (
   input  logic        clock,
   input  logic        reset,
   input  logic [31:0] s_avl_address,
   input  logic [3:0]  s_avl_byteenable,
   input  logic        s_avl_lock,
   input  logic        s_avl_read,
   input  logic [31:0] s_avl_writedata,
   input  logic        s_avl_write,
   input  logic [2:0]  s_avl_burstcount,
   output logic [31:0] s_avl_readdata,
   output logic [1:0]  s_avl_response,
   output logic        s_avl_waitrequest,
   output logic        s_avl_readdatavalid,
   output logic        s_avl_writeresponsevalid
);
   localparam int AW = $clog2(DEPTH);

   avl_slave_state_t r_state;
   logic [29:0]      r_addr;
   logic [2:0]       r_left;
   logic             r_rdv;

   logic [29:0]      w_idx;
   logic             w_in_range;
   logic [2:0]       w_count;
   logic             w_accept_wr;
   logic             w_accept_rd;
   logic             w_wbeat;
   logic             w_rbeat;
   logic             w_we;

   assign w_count     = (s_avl_burstcount == 3'd0) ? 3'd1 : s_avl_burstcount;
   // In IDLE the first beat is addressed straight from the bus so beat 0 returns one cycle later.
   assign w_idx       = (r_state == IDLE) ? s_avl_address[31:2] : r_addr;
   assign w_in_range  = (w_idx < 30'(DEPTH));
   assign w_accept_wr = (r_state == IDLE) && s_avl_write;
   assign w_accept_rd = (r_state == IDLE) && s_avl_read && !s_avl_write;
   assign w_wbeat     = w_accept_wr || ((r_state == WBURST) && s_avl_write);
   assign w_rbeat     = w_accept_rd || ((r_state == RBURST) && (r_left != 3'd0));
   assign w_we        = w_wbeat && w_in_range && !reset;

   avl_slave_ram #(.DEPTH(DEPTH), .AW(AW)) u_ram (
      .i_clk     (clock),
      .i_rst     (reset),
      .i_we      (w_we),
      .i_be      (s_avl_byteenable),
      .i_addr    (w_idx[AW-1:0]),
      .i_wdata   (s_avl_writedata),
      .i_re      (w_rbeat),
      .i_rd_zero (!w_in_range),
      .o_rdata   (s_avl_readdata)
   );

   assign s_avl_waitrequest   = reset || (r_state == RBURST) || (r_state == WRESP);
   assign s_avl_readdatavalid = r_rdv;

`ifdef AVL_SLAVE_RESP_EN
   logic       r_err;
   logic [1:0] r_resp;
   logic       r_wrv;
   logic       w_werr;

   assign w_werr                   = ((r_state == WBURST) && r_err) || !w_in_range;
   assign s_avl_response           = r_resp;
   assign s_avl_writeresponsevalid = r_wrv;
`else
   logic w_unused;

   assign w_unused                 = &{1'b0, AVL_DECODEERROR};
   assign s_avl_response           = AVL_OKAY;
   assign s_avl_writeresponsevalid = 1'b0;
`endif

   logic w_unused_bus;
   assign w_unused_bus = &{1'b0, s_avl_lock, s_avl_address[1:0]};

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state <= IDLE;
         r_addr  <= '0;
         r_left  <= '0;
         r_rdv   <= 1'b0;
`ifdef AVL_SLAVE_RESP_EN
         r_err   <= 1'b0;
         r_resp  <= AVL_OKAY;
         r_wrv   <= 1'b0;
`endif
      end else begin
         r_rdv <= w_rbeat;
`ifdef AVL_SLAVE_RESP_EN
         r_wrv <= 1'b0;
         if (w_rbeat) begin
            r_resp <= w_in_range ? AVL_OKAY : AVL_DECODEERROR;
         end
`endif
         case (r_state)
            IDLE: begin
               if (s_avl_write) begin
                  r_addr <= w_idx + 30'd1;
                  r_left <= w_count - 3'd1;
`ifdef AVL_SLAVE_RESP_EN
                  r_err  <= !w_in_range;
`endif
                  if (w_count == 3'd1) begin
`ifdef AVL_SLAVE_RESP_EN
                     r_state <= WRESP;
                     r_wrv   <= 1'b1;
                     r_resp  <= w_werr ? AVL_DECODEERROR : AVL_OKAY;
`else
                     r_state <= IDLE;
`endif
                  end else begin
                     r_state <= WBURST;
                  end
               end else if (s_avl_read) begin
                  r_addr  <= w_idx + 30'd1;
                  r_left  <= w_count - 3'd1;
                  r_state <= RBURST;
               end
            end
            RBURST: begin
               if (r_left != 3'd0) begin
                  r_addr <= r_addr + 30'd1;
                  r_left <= r_left - 3'd1;
               end else begin
                  r_state <= IDLE;
               end
            end
            WBURST: begin
               if (s_avl_write) begin
                  r_addr <= r_addr + 30'd1;
                  r_left <= r_left - 3'd1;
`ifdef AVL_SLAVE_RESP_EN
                  r_err  <= w_werr;
`endif
                  if (r_left == 3'd1) begin
`ifdef AVL_SLAVE_RESP_EN
                     r_state <= WRESP;
                     r_wrv   <= 1'b1;
                     r_resp  <= w_werr ? AVL_DECODEERROR : AVL_OKAY;
`else
                     r_state <= IDLE;
`endif
                  end
               end
            end
            WRESP: r_state <= IDLE;
            default: r_state <= IDLE;
         endcase
      end
   end
endmodule

// File: doc/avl_slave.md
# avl_slave

Avalon-MM responder that terminates the bus driven by the SoC's Avalon master port. It accepts single and burst reads and writes and backs them with an internal byte-enabled word memory. It is the bench and FPGA stand-in for external memory on the `m_avl_*` interface, and is instantiated beside `soc` with its ports wired one-to-one to `m_avl_*`.

## Interface
- `DEPTH`, 4096: memory size in 32-bit words; must be a power of two.
- `clock` in 1: single clock; all logic is rising-edge.
- `reset` in 1: asynchronous, active-high.
- `s_avl_address` in 32: byte address; bits [1:0] are ignored.
- `s_avl_byteenable` in 4: write byte lanes.
- `s_avl_lock` in 1: accepted and ignored.
- `s_avl_read` in 1: read command.
- `s_avl_writedata` in 32: write data.
- `s_avl_write` in 1: write command or write data beat.
- `s_avl_burstcount` in 3: beats per burst, 1–7; 0 is treated as 1.
- `s_avl_readdata` out 32: read beat data.
- `s_avl_response` out 2: 00 means OKAY, 11 means DECODEERROR.
- `s_avl_waitrequest` out 1: stall.
- `s_avl_readdatavalid` out 1: read beat valid.
- `s_avl_writeresponsevalid` out 1: write burst response valid.

## Operation
- States:
  - `IDLE`: waitrequest=0; accepts a command.
  - `RBURST`: waitrequest=1; streams read beats.
  - `WBURST`: waitrequest=0; takes write beats 2..N.
  - `WRESP`: waitrequest=1; issues the write response.
- Transitions from `IDLE`:
  - `write`=1: latch address and count, write beat 1. Go to `WBURST` if count>1, otherwise to `WRESP`.
  - `read`=1 and `write`=0: latch address and count, go to `RBURST`.
  - `read` and `write` both 1: protocol violation; write wins and read is dropped.
- `RBURST`:
  - One beat per cycle, no gaps.
  - Word index = latched word + beat number.
  - Return to `IDLE` after the last beat.
- `WBURST`:
  - A beat is taken on each cycle with `write`=1.
  - Cycles with `write`=0 are idle cycles and do not count as beats.
  - `read` is ignored in this state.
  - Go to `WRESP` after beat N.
- `WRESP`: one cycle, then `IDLE`.
- Address arithmetic:
  - Word index = `address[31:2]` + beat, computed 30-bit and wrapping mod 2^30.
  - The index is in range when it is less than `DEPTH`.
  - An out-of-range write beat is discarded.
  - An out-of-range read beat returns 0.
- Byte enables:
  - Lane i writes bits [8i+7:8i].
  - `byteenable`=0000 writes nothing but still counts as a beat.
- Memory contents are not cleared by reset.

## Timing
- Reset values:
  - readdata=0, response=00, readdatavalid=0, writeresponsevalid=0, state=`IDLE`.
  - waitrequest is forced to 1 while `reset` is high.
- Read:
  - Command accepted at cycle T.
  - Beat k (0-based) has readdatavalid=1 at T+1+k.
  - The next command is accepted no earlier than T+1+N.
- Write:
  - Last beat at cycle W.
  - Response at W+1: with `AVL_SLAVE_RESP_EN` defined, writeresponsevalid=1 for one cycle with the response; without it, no response is issued (see Configuration).
  - The next command is accepted at W+2.
- Read-after-write to the same word returns the new data with no hazard.
- All outputs are registered except waitrequest, which is decoded from the state register and `reset`.
- Reset mid-burst: return immediately to `IDLE` and drop remaining beats. Writes already committed stay in memory.

## Configuration
- `AVL_SLAVE_RESP_EN` defined:
  - writeresponsevalid is generated.
  - A write response is 11 if any beat of the burst was out of range, otherwise 00.
  - Each read beat carries 11 if it was out of range, otherwise 00.
- `AVL_SLAVE_RESP_EN` undefined:
  - writeresponsevalid is tied to 0 and response is tied to 00.
  - `WRESP` is skipped; the last write beat goes straight to `IDLE`, so the next command is accepted at W+1.
  - Out-of-range beats still discard writes and return 0 on reads.

## Structure
- `configure` package holds:
  - `avl_depth` constant.
  - Avalon response constants: OKAY=2'b00, DECODEERROR=2'b11.
  - State enum type `avl_slave_state_t`.
- Sub-module `avl_slave_ram`: single-port, 32-bit, byte-enabled write, registered read, `DEPTH` parameter. It is the natural target for FPGA block-RAM inference.
- `avl_slave` holds the FSM, beat counter, address register and response logic.

## Test plan
- Single write then read: write 0x10 ← 0xDEADBEEF with be=1111, then read 0x10 with burst 1 → readdatavalid at T+1 with 0xDEADBEEF, response 00.
- Byte lanes: write 0x20 ← 0xFFFFFFFF, then write 0x20 ← 0x00000000 with be=0101, then read → 0xFF00FF00.
- Burst write 4 with an idle cycle between beats 2 and 3, then burst read 4 from 0x100 → four consecutive beats with the written data; waitrequest=1 during read beats; writeresponsevalid exactly once, one cycle after beat 4.
- Out of range (`RESP_EN` defined): write burst 2 at byte (DEPTH−1)×4 → response 11, last word written, no alias at word 0. Read burst 2 at the same address → beat 0 data with response 00, beat 1 = 0 with response 11.
- Reset mid read burst of 7 after beat 2 → readdatavalid drops to 0, waitrequest=1 during reset then 0, next read returns correct data.
- Simultaneous read and write in `IDLE` at 0x40 with data 0x12345678 → write is performed, no readdatavalid is produced, and a later read returns 0x12345678.
